// File: rtl/boolexp_sweep_ctrl.sv
// Exhaustive truth-table sequencer: drives every input vector, samples dut_y after SETTLE cycles,
// and reports the captured table, the mismatch count against EXPECT and a pass flag.
module boolexp_sweep_ctrl #(
  parameter int                   N_IN   = 3,
  parameter int                   SETTLE = 2,
  parameter logic [(2**N_IN)-1:0] EXPECT = 8'hFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   dut_y_i,
  output logic [N_IN-1:0]        dut_in_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [N_IN:0]          mismatch_cnt_o,
  output logic [(2**N_IN)-1:0]   tt_o
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST    = '1;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NV-1:0]   tt_q, tt_d;
  logic [N_IN:0]   mm_q, mm_d;
  logic            pass_q, pass_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      mm_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_APPLY;
          idx_d   = '0;
          cnt_d   = '0;
          tt_d    = '0;
          mm_d    = '0;
          pass_d  = 1'b0;
        end
      end
      S_APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        tt_d[idx_q] = dut_y_i;
        // Count width holds 2**N_IN, so this increment never wraps.
        if (dut_y_i != EXPECT[idx_q]) mm_d = mm_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        pass_d  = (mm_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o         = (state_q != S_IDLE);
    done_o         = (state_q == S_DONE);
    dut_in_o       = (state_q == S_IDLE) ? '0 : idx_q;
    // pass is already valid during the done pulse, then held from the register.
    pass_o         = (state_q == S_DONE) ? (mm_q == '0) : pass_q;
    mismatch_cnt_o = mm_q;
    tt_o           = tt_q;
  end

endmodule

// File: tb/tb_boolexp_sweep_ctrl.sv
// Randomized scoreboard bench for boolexp_sweep_ctrl; the DUT-under-sweep is a truth-table lookup.
module tb_boolexp_sweep_ctrl;

  localparam int          NV      = 8;
  localparam int          VEC_CYC = 3;
  localparam int          SWEEP   = NV * VEC_CYC;
  localparam logic [7:0]  EXP     = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dut_y;
  logic [2:0] dut_in;
  logic       busy, done, pass;
  logic [3:0] mm;
  logic [7:0] tt;
  logic [7:0] func = 8'h00;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] tt;
    int         mm;
    logic       pass;
    int         accept;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dut_y = func[dut_in];

  boolexp_sweep_ctrl #(.N_IN(3), .SETTLE(2), .EXPECT(EXP)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .dut_y_i        (dut_y),
    .dut_in_o       (dut_in),
    .busy_o         (busy),
    .done_o         (done),
    .pass_o         (pass),
    .mismatch_cnt_o (mm),
    .tt_o           (tt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] f, input int accept);
    exp_t e;
    e.tt     = f;
    e.mm     = $countones(f ^ EXP);
    e.pass   = (e.mm == 0);
    e.accept = accept;
    return e;
  endfunction

  // Monitor: checks busy/dut_in against the front sweep and scores each done pulse.
  initial begin
    forever begin
      int k;
      @(negedge clk);
      if (q.size() == 0 || cyc < q[0].accept) begin
        check("busy_idle", busy, 0);
        check("done_idle", done, 0);
        check("dut_in_idle", dut_in, 0);
      end else begin
        k = cyc - q[0].accept;
        check("busy_run", busy, 1);
        check("dut_in_run", dut_in, (k / VEC_CYC > NV - 1) ? NV - 1 : k / VEC_CYC);
        if (k == SWEEP) begin
          check("done_pulse", done, 1);
          check("tt", tt, q[0].tt);
          check("mismatch_cnt", mm, q[0].mm);
          check("pass", pass, q[0].pass);
          void'(q.pop_front());
        end else if (k > SWEEP) begin
          check("done_missing", done, 1);
          void'(q.pop_front());
        end else begin
          check("done_early", done, 0);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] f, output int accept);
    @(negedge clk);
    func   = f;
    start  = 1'b1;
    accept = cyc + 1;
    q.push_back(model(f, accept));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL timeout: %0d sweeps still pending, expected 0", q.size());
    q.delete();
  endtask

  task automatic run_sweep(input logic [7:0] f);
    int   a;
    exp_t e;
    e = model(f, 0);
    issue(f, a);
    wait_idle();
    repeat (3) @(negedge clk);
    check("tt_hold", tt, e.tt);
    check("mm_hold", mm, e.mm);
    check("pass_hold", pass, e.pass);
  endtask

  initial begin
    int a;
    logic [7:0] f;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_tt", tt, 0);
    check("rst_mm", mm, 0);
    rst = 1'b0;

    run_sweep(8'hFF);   // tautology
    run_sweep(8'h80);   // a&b&c
    run_sweep(8'h55);   // ~c
    run_sweep(8'h00);   // every vector mismatches: full-scale count
    repeat (6) run_sweep(8'($urandom_range(0, 255)));

    // start re-pulsed mid-sweep must be ignored
    issue(8'hA5, a);
    while (cyc < a + 10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (30) @(negedge clk);

    // reset mid-sweep: no done pulse, outputs cleared, then a clean sweep
    issue(8'h3C, a);
    while (cyc < a + 12) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_dut_in", dut_in, 0);
    check("midrst_tt", tt, 0);
    check("midrst_mm", mm, 0);
    check("midrst_pass", pass, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run_sweep(8'hC3);

    // start held high: back-to-back sweeps with one idle cycle between them
    f = 8'($urandom_range(0, 255));
    @(negedge clk);
    func  = f;
    start = 1'b1;
    a     = cyc + 1;
    q.push_back(model(f, a));
    q.push_back(model(f, a + SWEEP + 2));
    repeat (50) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
